dma_axil_arbiter: RTL and testbench



---
 rtl/dma_axil_arbiter_pkg.sv | 35 +++
 rtl/dma_axil_arbiter_rr_arbiter.sv | 45 ++++
 rtl/dma_axil_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_dma_axil_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_axil_arbiter_pkg.sv
// Shared definitions for the AXI-Lite register-port arbiter in front of the SGDMA controller.
package dma_axil_arbiter_pkg;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Fixed AXI-Lite side attributes
    localparam logic [3:0] AXI_WSTRB_ALL = 4'hF;
    localparam logic [2:0] AXI_PROT_DFLT = 3'b000;

    // DMA register offsets used by the local clients
    localparam logic [15:0] REG_H2C0_STATUS = 16'h0040;
    localparam logic [15:0] REG_C2H0_STATUS = 16'h1040;

    // Round-robin pointer advance: idx+1, wrapping n-1 back to 0
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/dma_axil_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module dma_axil_arbiter_rr_arbiter
    import dma_axil_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);

    int             cand_s;
    logic [IDX_W-1:0] cand_idx_s;
    logic           found_s;

    // Rotate the priority so that ptr_i is searched first
    always_comb begin
        gnt_oh_o   = '0;
        gnt_idx_o  = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = int'(ptr_i) + i;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!found_s && req_i[cand_idx_s]) begin
                found_s               = 1'b1;
                gnt_idx_o             = cand_idx_s;
                gnt_oh_o[cand_idx_s]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        gnt_vld_o = found_s;
    end

endmodule

// File: rtl/dma_axil_arbiter.sv
// Shares the SGDMA AXI-Lite slave register port among NUM_REQ local clients,
// one transaction at a time, round-robin.
module dma_axil_arbiter
    import dma_axil_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int TMO_CYC = 1024
) (
    input  logic                      usr_clk,
    input  logic                      usr_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*32-1:0]     req_wdata_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      busy_o,
    output logic                      tmo_o,
    output logic [31:0]               m_axil_awaddr_o,
    output logic [2:0]                m_axil_awprot_o,
    output logic                      m_axil_awvalid_o,
    input  logic                      m_axil_awready_i,
    output logic [31:0]               m_axil_wdata_o,
    output logic [3:0]                m_axil_wstrb_o,
    output logic                      m_axil_wvalid_o,
    input  logic                      m_axil_wready_i,
    input  logic                      m_axil_bvalid_i,
    input  logic [1:0]                m_axil_bresp_i,
    output logic                      m_axil_bready_o,
    output logic [31:0]               m_axil_araddr_o,
    output logic [2:0]                m_axil_arprot_o,
    output logic                      m_axil_arvalid_o,
    input  logic                      m_axil_arready_i,
    input  logic [31:0]               m_axil_rdata_i,
    input  logic [1:0]                m_axil_rresp_i,
    input  logic                      m_axil_rvalid_i,
    output logic                      m_axil_rready_o
);

    localparam int          IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    state_t               state_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [NUM_REQ-1:0]   gnt_oh_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [31:0]          wdata_r;
    logic [NUM_REQ-1:0]   ack_r;
    logic [31:0]          rdata_r;
    logic                 err_r;
    logic                 busy_r;
    logic                 awvalid_r;
    logic                 wvalid_r;
    logic                 bready_r;
    logic                 arvalid_r;
    logic                 rready_r;
    logic [15:0]          cnt_r;
    logic                 tmo_r;

    logic [NUM_REQ-1:0]   gnt_oh_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic                 gnt_vld_s;
    logic                 aw_done_s;
    logic                 w_done_s;
    logic                 unused_resp_s;

    dma_axil_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_r),
        .gnt_oh_o  (gnt_oh_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (gnt_vld_s)
    );

    // Only resp[1] distinguishes error from success on AXI-Lite
    assign unused_resp_s = ^{m_axil_rresp_i[0], m_axil_bresp_i[0]};

    // A write channel is finished once its valid is gone or handshakes now
    assign aw_done_s = !awvalid_r || m_axil_awready_i;
    assign w_done_s  = !wvalid_r  || m_axil_wready_i;

    // Transaction sequencer with registered AXI and requester outputs
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            gnt_oh_r  <= '0;
            addr_r    <= '0;
            wdata_r   <= 32'h0000_0000;
            ack_r     <= '0;
            rdata_r   <= 32'h0000_0000;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= '0;
                    if (gnt_vld_s) begin
                        gnt_oh_r <= gnt_oh_s;
                        addr_r   <= req_addr_i[32'(gnt_idx_s)*ADDR_W +: ADDR_W];
                        wdata_r  <= req_wdata_i[32'(gnt_idx_s)*32 +: 32];
                        ptr_r    <= IDX_W'(rr_next(32'(gnt_idx_s), unsigned'(NUM_REQ)));
                        busy_r   <= 1'b1;
                        if (req_we_i[gnt_idx_s]) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= ST_WR_AW;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= ST_RD_A;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_A: begin
                    if (m_axil_arready_i) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_RD_D;
                    end else begin
                        state_r <= ST_RD_A;
                    end
                end
                ST_RD_D: begin
                    if (m_axil_rvalid_i) begin
                        rready_r <= 1'b0;
                        rdata_r  <= m_axil_rdata_i;
                        err_r    <= m_axil_rresp_i[1];
                        ack_r    <= gnt_oh_r;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_RD_D;
                    end
                end
                ST_WR_AW: begin
                    if (awvalid_r && m_axil_awready_i) begin
                        awvalid_r <= 1'b0;
                    end else begin
                        awvalid_r <= awvalid_r;
                    end
                    if (wvalid_r && m_axil_wready_i) begin
                        wvalid_r <= 1'b0;
                    end else begin
                        wvalid_r <= wvalid_r;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_r <= 1'b1;
                        state_r  <= ST_WR_B;
                    end else begin
                        state_r <= ST_WR_AW;
                    end
                end
                ST_WR_B: begin
                    if (m_axil_bvalid_i) begin
                        bready_r <= 1'b0;
                        rdata_r  <= 32'h0000_0000;
                        err_r    <= m_axil_bresp_i[1];
                        ack_r    <= gnt_oh_r;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_WR_B;
                    end
                end
                ST_DONE: begin
                    ack_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack_r     <= '0;
                    busy_r    <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Response watchdog: counts busy cycles, flags (never aborts) a stuck slave
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            cnt_r <= 16'h0000;
            tmo_r <= 1'b0;
        end else begin
            if (state_r == ST_IDLE) begin
                cnt_r <= 16'h0000;
            end else if (cnt_r != 16'hFFFF) begin
                cnt_r <= cnt_r + 16'h0001;
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r != ST_IDLE) && (cnt_r == TMO_LAST)) begin
                tmo_r <= 1'b1;
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end

    assign req_ack_o        = ack_r;
    assign rsp_rdata_o      = rdata_r;
    assign rsp_err_o        = err_r;
    assign busy_o           = busy_r;
    assign tmo_o            = tmo_r;
    assign m_axil_awaddr_o  = {{(32-ADDR_W){1'b0}}, addr_r};
    assign m_axil_araddr_o  = {{(32-ADDR_W){1'b0}}, addr_r};
    assign m_axil_awprot_o  = AXI_PROT_DFLT;
    assign m_axil_arprot_o  = AXI_PROT_DFLT;
    assign m_axil_awvalid_o = awvalid_r;
    assign m_axil_wdata_o   = wdata_r;
    assign m_axil_wstrb_o   = AXI_WSTRB_ALL;
    assign m_axil_wvalid_o  = wvalid_r;
    assign m_axil_bready_o  = bready_r;
    assign m_axil_arvalid_o = arvalid_r;
    assign m_axil_rready_o  = rready_r;

endmodule

// File: tb/tb_dma_axil_arbiter.sv
// Scoreboard bench for dma_axil_arbiter: directed requests push expected
// responses; a negedge monitor pops and compares on every ack pulse.
module tb_dma_axil_arbiter;
    import dma_axil_arbiter_pkg::*;

    localparam int NR  = 3;
    localparam int AW  = 16;
    localparam int TMO = 1024;

    logic              usr_clk = 1'b0;
    logic              usr_rst_n = 1'b0;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_we_i;
    logic [NR*AW-1:0]  req_addr_i;
    logic [NR*32-1:0]  req_wdata_i;
    logic [NR-1:0]     req_ack_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              busy_o;
    logic              tmo_o;
    logic [31:0]       m_axil_awaddr_o;
    logic [2:0]        m_axil_awprot_o;
    logic              m_axil_awvalid_o;
    logic              m_axil_awready_i;
    logic [31:0]       m_axil_wdata_o;
    logic [3:0]        m_axil_wstrb_o;
    logic              m_axil_wvalid_o;
    logic              m_axil_wready_i;
    logic              m_axil_bvalid_i;
    logic [1:0]        m_axil_bresp_i;
    logic              m_axil_bready_o;
    logic [31:0]       m_axil_araddr_o;
    logic [2:0]        m_axil_arprot_o;
    logic              m_axil_arvalid_o;
    logic              m_axil_arready_i;
    logic [31:0]       m_axil_rdata_i;
    logic [1:0]        m_axil_rresp_i;
    logic              m_axil_rvalid_i;
    logic              m_axil_rready_o;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ack_cnt = 0;
    int   last_wait = 0;

    always #5 usr_clk = ~usr_clk;

    dma_axil_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TMO_CYC(TMO)) dut (
        .usr_clk          (usr_clk),
        .usr_rst_n        (usr_rst_n),
        .req_valid_i      (req_valid_i),
        .req_we_i         (req_we_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_ack_o        (req_ack_o),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_err_o        (rsp_err_o),
        .busy_o           (busy_o),
        .tmo_o            (tmo_o),
        .m_axil_awaddr_o  (m_axil_awaddr_o),
        .m_axil_awprot_o  (m_axil_awprot_o),
        .m_axil_awvalid_o (m_axil_awvalid_o),
        .m_axil_awready_i (m_axil_awready_i),
        .m_axil_wdata_o   (m_axil_wdata_o),
        .m_axil_wstrb_o   (m_axil_wstrb_o),
        .m_axil_wvalid_o  (m_axil_wvalid_o),
        .m_axil_wready_i  (m_axil_wready_i),
        .m_axil_bvalid_i  (m_axil_bvalid_i),
        .m_axil_bresp_i   (m_axil_bresp_i),
        .m_axil_bready_o  (m_axil_bready_o),
        .m_axil_araddr_o  (m_axil_araddr_o),
        .m_axil_arprot_o  (m_axil_arprot_o),
        .m_axil_arvalid_o (m_axil_arvalid_o),
        .m_axil_arready_i (m_axil_arready_i),
        .m_axil_rdata_i   (m_axil_rdata_i),
        .m_axil_rresp_i   (m_axil_rresp_i),
        .m_axil_rvalid_i  (m_axil_rvalid_i),
        .m_axil_rready_o  (m_axil_rready_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(negedge usr_clk);
    endtask

    task automatic issue(input int idx, input logic we, input logic [15:0] addr, input logic [31:0] wd);
        req_we_i[idx]             = we;
        req_addr_i[idx*AW +: AW]  = addr;
        req_wdata_i[idx*32 +: 32] = wd;
        req_valid_i[idx]          = 1'b1;
    endtask

    task automatic expect_rsp(input int idx, input logic [31:0] rd, input logic err);
        exp_t e;
        e.idx = idx;
        e.rdata = rd;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Slave side of one read; wait_cyc stalls arready, watching tmo_o on the way
    task automatic serve_read(input int idx, input logic [31:0] exp_addr, input int wait_cyc,
                              input logic [31:0] data, input logic [1:0] resp);
        int n;
        int k;
        n = 0;
        while (m_axil_arvalid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        last_wait = n;
        chk("arvalid_up", 32'(m_axil_arvalid_o), 32'd1);
        chk("araddr", m_axil_araddr_o, exp_addr);
        chk("busy_rd", 32'(busy_o), 32'd1);
        k = 1;
        for (int w = 0; w < wait_cyc; w++) begin
            if (k == TMO) begin
                chk("tmo_before", 32'(tmo_o), 32'd0);
            end else if (k == TMO + 1) begin
                chk("tmo_after", 32'(tmo_o), 32'd1);
            end
            tick();
            k++;
        end
        chk("arvalid_held", 32'(m_axil_arvalid_o), 32'd1);
        m_axil_arready_i = 1'b1;
        tick();
        m_axil_arready_i = 1'b0;
        chk("arvalid_drop", 32'(m_axil_arvalid_o), 32'd0);
        chk("rready_up", 32'(m_axil_rready_o), 32'd1);
        m_axil_rdata_i  = data;
        m_axil_rresp_i  = resp;
        m_axil_rvalid_i = 1'b1;
        tick();
        m_axil_rvalid_i = 1'b0;
        m_axil_rdata_i  = 32'h0;
        m_axil_rresp_i  = 2'b00;
        chk("rd_ack_now", 32'(req_ack_o), 32'd1 << idx);
        chk("rready_drop", 32'(m_axil_rready_o), 32'd0);
    endtask

    // Slave side of AW/W: awready after aw_wait cycles, wready after w_wait cycles
    task automatic serve_write(input logic [31:0] exp_addr, input logic [31:0] exp_data,
                               input int aw_wait, input int w_wait);
        int n;
        int mx;
        n = 0;
        while (m_axil_awvalid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("awvalid_up", 32'(m_axil_awvalid_o), 32'd1);
        chk("wvalid_up", 32'(m_axil_wvalid_o), 32'd1);
        chk("awaddr", m_axil_awaddr_o, exp_addr);
        chk("wdata", m_axil_wdata_o, exp_data);
        chk("wstrb", 32'(m_axil_wstrb_o), 32'hF);
        mx = (aw_wait > w_wait) ? aw_wait : w_wait;
        for (int c = 0; c <= mx; c++) begin
            m_axil_awready_i = (c == aw_wait);
            m_axil_wready_i  = (c == w_wait);
            tick();
            chk("awvalid_seq", 32'(m_axil_awvalid_o), 32'(c < aw_wait));
            chk("wvalid_seq", 32'(m_axil_wvalid_o), 32'(c < w_wait));
            chk("bready_seq", 32'(m_axil_bready_o), 32'(c == mx));
        end
        m_axil_awready_i = 1'b0;
        m_axil_wready_i  = 1'b0;
    endtask

    task automatic serve_b(input int idx, input logic [1:0] resp);
        m_axil_bresp_i  = resp;
        m_axil_bvalid_i = 1'b1;
        tick();
        m_axil_bvalid_i = 1'b0;
        m_axil_bresp_i  = 2'b00;
        chk("wr_ack_now", 32'(req_ack_o), 32'd1 << idx);
        chk("bready_drop", 32'(m_axil_bready_o), 32'd0);
    endtask

    // Monitor: every ack pulse is matched against the oldest expected response
    always @(negedge usr_clk) begin
        if (usr_rst_n === 1'b1 && req_ack_o !== '0) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected: actual=%b required=none", req_ack_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_ack_vec", 32'(req_ack_o), 32'd1 << e.idx);
                chk("sb_rdata", rsp_rdata_o, e.rdata);
                chk("sb_err", 32'(rsp_err_o), 32'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_i = '0;
        req_we_i = '0;
        req_addr_i = '0;
        req_wdata_i = '0;
        m_axil_awready_i = 1'b0;
        m_axil_wready_i = 1'b0;
        m_axil_bvalid_i = 1'b0;
        m_axil_bresp_i = 2'b00;
        m_axil_arready_i = 1'b0;
        m_axil_rdata_i = 32'h0;
        m_axil_rresp_i = 2'b00;
        m_axil_rvalid_i = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_ack", 32'(req_ack_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_tmo", 32'(tmo_o), 32'd0);
        chk("rst_arvalid", 32'(m_axil_arvalid_o), 32'd0);
        chk("rst_awvalid", 32'(m_axil_awvalid_o), 32'd0);
        chk("rst_wvalid", 32'(m_axil_wvalid_o), 32'd0);
        chk("rst_bready", 32'(m_axil_bready_o), 32'd0);
        chk("rst_rready", 32'(m_axil_rready_o), 32'd0);
        chk("rst_wstrb", 32'(m_axil_wstrb_o), 32'hF);
        chk("rst_prot", 32'({m_axil_awprot_o, m_axil_arprot_o}), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        usr_rst_n = 1'b1;
        tick();

        // All three requesters held: grants 0,1,2,0,1,2 with one IDLE gap each
        issue(0, 1'b0, 16'h0100, 32'h0);
        issue(1, 1'b0, 16'h0200, 32'h0);
        issue(2, 1'b0, 16'h0300, 32'h0);
        for (int t = 0; t < 6; t++) begin
            expect_rsp(t % 3, 32'h1000 + t, 1'b0);
            serve_read(t % 3, 32'h100 * ((t % 3) + 1), 0, 32'h1000 + t, AXI_RESP_OKAY);
            chk("b2b_gap", last_wait, 32'd1);
            if (t == 5) begin
                req_valid_i = '0;
            end
            tick();
            chk("busy_idle", 32'(busy_o), 32'd0);
        end

        // req1 reads C2H0 status, slave stalls arready 2 cycles
        issue(1, 1'b0, REG_C2H0_STATUS, 32'h0);
        expect_rsp(1, 32'hA5A5_0001, 1'b0);
        serve_read(1, 32'h0000_1040, 2, 32'hA5A5_0001, AXI_RESP_OKAY);
        req_valid_i[1] = 1'b0;
        tick();

        // req0 writes, awready 3 cycles ahead of wready
        issue(0, 1'b1, 16'h0004, 32'h0000_0001);
        expect_rsp(0, 32'h0, 1'b0);
        serve_write(32'h0000_0004, 32'h0000_0001, 0, 3);
        serve_b(0, AXI_RESP_OKAY);
        req_valid_i[0] = 1'b0;
        tick();

        // SLVERR read, then an OKAY unaligned write with wready ahead of awready
        issue(2, 1'b0, REG_H2C0_STATUS, 32'h0);
        expect_rsp(2, 32'hDEAD_BEEF, 1'b1);
        serve_read(2, 32'h0000_0040, 0, 32'hDEAD_BEEF, AXI_RESP_SLVERR);
        req_valid_i[2] = 1'b0;
        tick();
        issue(1, 1'b1, 16'h000B, 32'h0000_0005);
        expect_rsp(1, 32'h0, 1'b0);
        serve_write(32'h0000_000B, 32'h0000_0005, 2, 0);
        serve_b(1, AXI_RESP_OKAY);
        req_valid_i[1] = 1'b0;
        tick();

        // Stalled arready beyond the timeout: flag sets, transaction still completes
        chk("tmo_pre", 32'(tmo_o), 32'd0);
        issue(0, 1'b0, 16'h0010, 32'h0);
        expect_rsp(0, 32'h0000_0077, 1'b0);
        serve_read(0, 32'h0000_0010, TMO + 5, 32'h0000_0077, AXI_RESP_OKAY);
        req_valid_i[0] = 1'b0;
        tick();
        tick();
        chk("tmo_sticky", 32'(tmo_o), 32'd1);

        // Reset while waiting for B: no ack, everything idle, pointer back to 0
        issue(0, 1'b1, 16'h0020, 32'h0000_CAFE);
        serve_write(32'h0000_0020, 32'h0000_CAFE, 0, 0);
        usr_rst_n = 1'b0;
        #1;
        chk("ar_bready", 32'(m_axil_bready_o), 32'd0);
        chk("ar_valids", 32'({m_axil_awvalid_o, m_axil_wvalid_o, m_axil_arvalid_o}), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_ack", 32'(req_ack_o), 32'd0);
        chk("ar_tmo", 32'(tmo_o), 32'd0);
        req_valid_i = '0;
        tick();
        tick();
        usr_rst_n = 1'b1;
        tick();
        issue(0, 1'b0, 16'h0030, 32'h0);
        issue(2, 1'b0, 16'h0050, 32'h0);
        expect_rsp(0, 32'h0000_0ABC, 1'b0);
        serve_read(0, 32'h0000_0030, 0, 32'h0000_0ABC, AXI_RESP_OKAY);
        req_valid_i = '0;
        tick();
        tick();
        tick();

        chk("acks_total", ack_cnt, 32'd12);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
